instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Parameters
REQ-001 SHALL have parameter ADDR_W, default 4, program-memory address width.
REQ-002 SHALL have parameter LOOP_START, default 2, first loop-body address; legal range 1..PROG_END.
REQ-003 SHALL have parameter PROG_END, default 4, last loop-body address; must be less than 2^ADDR_W.

Interface
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  begin program run; sampled only in IDLE.
REQ-007 SHALL have port n_iter  input  8  loop-body repeat count, captured when start is accepted.
REQ-008 SHALL have port hold  input  1  stall; while high, FETCH does not advance.
REQ-009 SHALL have port imem_addr  output  ADDR_W  program-memory address (= pc).
REQ-010 SHALL have port imem_data  input  7  instruction {op[6:4], opr1[3:2], opr2[1:0]}, valid the cycle after imem_addr.
REQ-011 SHALL have port op_code  output  3  opcode to decoder, registered.
REQ-012 SHALL have port opr1  output  2  operand 1 to decoder, registered.
REQ-013 SHALL have port opr2  output  2  operand 2 to decoder, registered.
REQ-014 SHALL have port issue  output  1  high for exactly one cycle per instruction presented.
REQ-015 SHALL have port busy  output  1  high in FETCH and EXEC.
REQ-016 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-017 SHALL have port iter_left  output  8  remaining loop passes, including the current pass.

Function
REQ-018 SHALL implement states IDLE, FETCH, EXEC, DONE.
REQ-019 IDLE: on start=1, pc <- 0, iter_left <- n_iter, next state FETCH; otherwise remain in IDLE.
REQ-020 FETCH: drive imem_addr=pc; next state EXEC if hold=0, else remain in FETCH.
REQ-021 EXEC: register imem_data into op_code/opr1/opr2; issue=1 for that cycle; then select next step by REQ-022..REQ-024.
REQ-022 pc==LOOP_START-1 and iter_left==0: next state DONE, with no body execution.
REQ-023 pc==PROG_END: if iter_left>1, iter_left decrements, pc <- LOOP_START, next state FETCH; otherwise iter_left <- 0, next state DONE.
REQ-024 All other cases: pc <- pc+1, next state FETCH.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 Whenever issue=0, op_code SHALL be 3'b000 (noop), and opr1 and opr2 SHALL be 0, so the decoder performs no write.
REQ-027 Latency: start accepted at edge k, hold=0 -> instruction i (1-based) issues in cycle k+2i; done is high the cycle after the last issue.
REQ-028 Instruction count per run SHALL be LOOP_START + n_iter*(PROG_END-LOOP_START+1).
REQ-029 start while busy or in DONE SHALL be ignored, with no effect on pc or iter_left.
REQ-030 hold SHALL be ignored outside FETCH; hold in FETCH only lengthens the run by the stalled cycles.
REQ-031 pc SHALL never exceed PROG_END; no wrap-around.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, pc=0, iter_left=0, op_code=0, opr1=0, opr2=0, issue=0, busy=0, done=0; this holds mid-run, and no further issue occurs.
REQ-033 After rst_n returns to 1, the block SHALL need a new start to run.

Verification
REQ-034 Default params, n_iter=3, start pulse -> addresses issued 0,1,2,3,4,2,3,4,2,3,4 (11 issues); done one cycle after 11th issue, at k+23.
REQ-035 n_iter=0 -> only addresses 0,1 issued; done at k+5; iter_left=0.
REQ-036 n_iter=1, hold=1 for 3 cycles during second FETCH -> issues 0..4, second issue at k+7, done at k+14.
REQ-037 rst_n=0 during EXEC of address 3 -> next cycle IDLE, all outputs 0; no done; start then reruns from address 0.
REQ-038 start pulsed while busy and in DONE -> ignored; pc sequence and iter_left unchanged.
REQ-039 Every cycle with issue=0 -> op_code=000; each issue lasts exactly one cycle; op_code/opr1/opr2 match imem contents of the issued address.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer: runs a prologue once, then repeats a loop body n_iter times,
// presenting each fetched instruction to the decoder as a one-cycle registered issue.
module instr_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int LOOP_START = 2,
    parameter int PROG_END   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        n_iter,
    input  logic              hold,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [6:0]        imem_data,
    output logic [2:0]        op_code,
    output logic [1:0]        opr1,
    output logic [1:0]        opr2,
    output logic              issue,
    output logic              busy,
    output logic              done,
    output logic [7:0]        iter_left,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LS_ADDR  = ADDR_W'(LOOP_START);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(LOOP_START - 1);
    localparam logic [ADDR_W-1:0] PE_ADDR  = ADDR_W'(PROG_END);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        iter_q, iter_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        opr1_q, opr1_d;
    logic [1:0]        opr2_q, opr2_d;
    logic              issue_q, issue_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            iter_q  <= '0;
            op_q    <= '0;
            opr1_q  <= '0;
            opr2_q  <= '0;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            op_q    <= op_d;
            opr1_q  <= opr1_d;
            opr2_q  <= opr2_d;
            issue_q <= issue_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iter_d  = iter_q;
        op_d    = '0;
        opr1_d  = '0;
        opr2_d  = '0;
        issue_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // The done pulse lands in the first IDLE cycle; it still belongs to the
                // finished run, so a start seen alongside it is not a new request.
                if (start && !done_q) begin
                    pc_d    = '0;
                    iter_d  = n_iter;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!hold) state_d = EXEC;
            end
            EXEC: begin
                issue_d = 1'b1;
                op_d    = imem_data[6:4];
                opr1_d  = imem_data[3:2];
                opr2_d  = imem_data[1:0];
                if (pc_q == PRE_LAST && iter_q == 8'd0) begin
                    state_d = DONE;
                end else if (pc_q == PE_ADDR) begin
                    if (iter_q > 8'd1) begin
                        iter_d  = iter_q - 8'd1;
                        pc_d    = LS_ADDR;
                        state_d = FETCH;
                    end else begin
                        iter_d  = 8'd0;
                        state_d = DONE;
                    end
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign op_code   = op_q;
    assign opr1      = opr1_q;
    assign opr2      = opr2_q;
    assign issue     = issue_q;
    assign done      = done_q;
    assign iter_left = iter_q;
    assign busy      = (state_q == FETCH) || (state_q == EXEC);
    assign dbg_state = state_q;

endmodule
